mips_lsu: RTL
=============

Name: mips_lsu

Overview:
- CPU-side load/store initiator for the MIPS word-addressed data memory bus. This is the bus master that drives the RAM's Clk/BE/CS/RW/Addr/DataIn/DataOut/DataReady interface.
- Accepts one load or store request at a time from the pipeline.
- Generates byte enables and aligned store data, issues the bus cycle and waits for DataReady.
- Extracts and sign- or zero-extends load data, then reports completion or error.

Parameters:
- TIMEOUT, 16, max WAIT cycles without BusDataReady before bus error; 0 = timeout disabled.
- CW, 5, timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  1  request strobe; sampled only in IDLE.
- Wr  in  1  1 = store, 0 = load.
- Size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- SignExt  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- VAddr  in  32  byte address.
- WData  in  32  store data, right-justified.
- Busy  out  1  high while state != IDLE.
- Done  out  1  one-cycle completion pulse.
- AddrErr  out  1  valid with Done: misaligned or reserved Size.
- BusErr  out  1  valid with Done: timeout.
- RData  out  32  load result; held until the next successful load.
- BusCS  out  1  bus chip select.
- BusRW  out  1  1 = write, 0 = read.
- BusBE  out  4  byte enables; bit i = byte lane i, little-endian.
- BusAddr  out  30  word address, VAddr[31:2].
- BusDataOut  out  32  store data to memory.
- BusDataIn  in  32  read data from memory.
- BusDataReady  in  1  memory ready/valid.

Behaviour:
- Reset, asynchronous, at any time including mid-transaction:
  - state = IDLE.
  - Done, AddrErr, BusErr, BusCS, BusRW = 0.
  - BusBE = 0, BusAddr = 0, BusDataOut = 0, RData = 0, timeout counter = 0.
  - No partial completion is reported.
- States: IDLE, ISSUE, WAIT.
- IDLE, Req=1, aligned:
  - Capture Wr, Size, SignExt and VAddr[1:0].
  - Register BusAddr, BusBE, BusRW and BusDataOut.
  - Next state ISSUE.
- IDLE, Req=1, misaligned. Misaligned means any of:
  - Size=01 with VAddr[0]=1.
  - Size=10 with VAddr[1:0] != 0.
  - Size=11.
- Misaligned response:
  - No bus cycle.
  - Next cycle: Done=1 and AddrErr=1 for one cycle.
  - State stays IDLE.
- ISSUE: BusCS=1 for exactly one cycle; next state WAIT; counter cleared.
- WAIT:
  - BusCS=0; BusAddr, BusBE, BusRW and BusDataOut stay held.
  - BusDataReady=1 on a rising edge, load: RData <= extracted value; Done=1 next cycle; next state IDLE.
  - BusDataReady=1 on a rising edge, store: Done=1 next cycle; next state IDLE.
  - BusDataReady=0: counter increments.
  - Counter reaching TIMEOUT (TIMEOUT != 0): Done=1 and BusErr=1 next cycle; RData unchanged; next state IDLE.
- Latency with an always-ready memory: Req sampled at edge 0, BusCS high in cycle 1, ready sampled at edge 2, Done high in cycle 3.
- Req in the same cycle Done is high: accepted, because the state is already IDLE. Back-to-back throughput is one transaction per 3 cycles.
- Req while Busy=1: ignored. No queueing; the requester holds Req until it sees Done.
- Byte enables:
  - Byte: BE = 4'b0001 << VAddr[1:0].
  - Half: BE = VAddr[1] ? 4'b1100 : 4'b0011.
  - Word: BE = 4'b1111.
- Store data lane replication:
  - Byte: {4{WData[7:0]}}.
  - Half: {2{WData[15:0]}}.
  - Word: WData.
- Load extraction:
  - Byte lane = BusDataIn >> (8*A[1:0]).
  - Half lane = BusDataIn >> (16*A[1]).
  - Extend to 32 bits per the captured SignExt.
  - Word: unchanged.
- Done, AddrErr and BusErr are registered single-cycle pulses. AddrErr and BusErr are never both high.

Decomposition:
- Package mips_mem_pkg:
  - SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State encodings: ST_IDLE, ST_ISSUE, ST_WAIT.
- Sub-module mips_lsu_align, purely combinational:
  - Misalignment check and BE generation.
  - Store lane replication.
  - Load lane extraction and extension.
- mips_lsu keeps the FSM, timeout counter and output registers.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x0000_0010 with always-ready memory:
  - BusCS high cycle 1 with BusAddr=0x4, BusBE=1111, BusRW=1.
  - Done cycle 3; read-back load returns RData=0xDEADBEEF.
- Load byte at 0x0000_0013, SignExt=1, memory word 0x80FF_0102:
  - BusBE=1000; RData=0xFFFF_FF80.
  - Same with SignExt=0: RData=0x0000_0080.
- Store half 0x1234 at 0x0000_0006:
  - BusBE=1100, BusDataOut=0x1234_1234, BusAddr=0x1.
- Load word at 0x0000_0002:
  - Done and AddrErr high the next cycle; BusCS never asserted; RData unchanged.
- BusDataReady held 0, TIMEOUT=16:
  - Done and BusErr pulse 16 WAIT cycles after ISSUE; Busy falls.
  - Assert Reset mid-WAIT on a second run: all outputs 0 immediately and Done is never produced.
- Req held continuously for three loads, memory ready every cycle:
  - Done in cycles 3, 6 and 9.
  - Req is ignored while Busy=1.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared size codes and LSU state encoding for the data memory bus.
package mips_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
endpackage

// File: rtl/mips_lsu_align.sv
// mips_lsu_align: alignment check, byte enables, store lane replication and load extraction.
module mips_lsu_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  Size,
  input  logic [1:0]  Addr,
  input  logic [31:0] WData,
  input  logic [1:0]  LdSize,
  input  logic [1:0]  LdAddr,
  input  logic        LdSignExt,
  input  logic [31:0] BusDataIn,
  output logic        Misaligned,
  output logic [3:0]  Be,
  output logic [31:0] StoreData,
  output logic [31:0] LoadData
);
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  always_comb begin
    Misaligned = (Size == 2'b11) || (Size == SZ_HALF && Addr[0]) || (Size == SZ_WORD && Addr != 2'b00);
    Be = Size == SZ_BYTE ? 4'b0001 << Addr : Size == SZ_HALF ? (Addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    StoreData = Size == SZ_BYTE ? {4{WData[7:0]}} : Size == SZ_HALF ? {2{WData[15:0]}} : WData;
    ldByte = 8'(BusDataIn >> {LdAddr, 3'b000});
    ldHalf = 16'(BusDataIn >> {LdAddr[1], 4'b0000});
    LoadData = LdSize == SZ_BYTE ? {{24{LdSignExt & ldByte[7]}}, ldByte}
             : LdSize == SZ_HALF ? {{16{LdSignExt & ldHalf[15]}}, ldHalf} : BusDataIn;
  end
endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: single-outstanding load/store bus master with timeout for the word-addressed data RAM.
module mips_lsu
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] VAddr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic        AddrErr,
  output logic        BusErr,
  output logic [31:0] RData,
  output logic        BusCS,
  output logic        BusRW,
  output logic [3:0]  BusBE,
  output logic [29:0] BusAddr,
  output logic [31:0] BusDataOut,
  input  logic [31:0] BusDataIn,
  input  logic        BusDataReady
);
  state_t state, stateNext;
  logic [1:0] capSize, capA;
  logic capSext;
  logic [CW-1:0] cnt;
  logic misaligned;
  logic [3:0] be;
  logic [31:0] stData, ldData;
  logic accept, addrFault, complete, timeout;

  mips_lsu_align uAlign (
    .Size(Size), .Addr(VAddr[1:0]), .WData(WData),
    .LdSize(capSize), .LdAddr(capA), .LdSignExt(capSext), .BusDataIn(BusDataIn),
    .Misaligned(misaligned), .Be(be), .StoreData(stData), .LoadData(ldData)
  );

  assign Busy = state != ST_IDLE;

  always_comb begin
    accept = state == ST_IDLE && Req && !misaligned;
    addrFault = state == ST_IDLE && Req && misaligned;
    complete = state == ST_WAIT && BusDataReady;
    timeout = state == ST_WAIT && !BusDataReady && TIMEOUT != 0 && cnt + CW'(1) == CW'(TIMEOUT);
    stateNext = accept ? ST_ISSUE : state == ST_ISSUE ? ST_WAIT : (complete || timeout) ? ST_IDLE : state;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      Done <= 1'b0;
      AddrErr <= 1'b0;
      BusErr <= 1'b0;
      BusCS <= 1'b0;
      BusRW <= 1'b0;
      BusBE <= '0;
      BusAddr <= '0;
      BusDataOut <= '0;
      RData <= '0;
      cnt <= '0;
      capSize <= '0;
      capA <= '0;
      capSext <= 1'b0;
    end else begin
      state <= stateNext;
      Done <= addrFault | complete | timeout;
      AddrErr <= addrFault;
      BusErr <= timeout;
      BusCS <= accept;
      cnt <= (state == ST_WAIT && !BusDataReady) ? cnt + CW'(1) : '0;
      if (accept) begin
        capSize <= Size;
        capA <= VAddr[1:0];
        capSext <= SignExt;
        BusRW <= Wr;
        BusBE <= be;
        BusAddr <= VAddr[31:2];
        BusDataOut <= stData;
      end
      // RData only moves on a successful load; stores and timeouts leave it alone
      if (complete && !BusRW) RData <= ldData;
    end
  end
endmodule
